aurora_block_sync_ctrl: RTL and testbench
=========================================

# aurora_block_sync_ctrl

Block-synchronisation controller for the Aurora 64b/66b receive lane. It watches the 2-bit sync headers produced by the lane gearbox and decides when to slip: a gearbox slip for each failed alignment attempt, and a serdes bit slip after a full 66-position sweep fails. It declares block lock after a run of valid headers and drops lock when too many bad headers arrive within a window. It sits inside `aurora_rx_lane` between the gearbox output and the descrambler/valid logic, in the `clk_rx_i` domain.

## Interface
- `LOCK_CNT`, 64: consecutive valid headers needed to declare lock.
- `ERR_LIMIT`, 16: bad headers within one window that cause loss of lock.
- `ERR_WINDOW`, 1024: header beats per error-counting window while locked.
- `SLIP_WAIT`, 32: header beats ignored after each slip, to let the gearbox/serdes settle.
- `GBOX_SLIPS`, 66: gearbox slips per serdes slip.

- `clk_rx_i`  in  1  lane clock; the only clock.
- `rst_n_i`  in  1  reset; synchronous, active-low.
- `hdr_i`  in  2  sync header of the current gearbox word.
- `hdr_valid_i`  in  1  `hdr_i` is valid this cycle (one beat).
- `gearbox_slip_o`  out  1  one-cycle slip pulse to the gearbox.
- `serdes_slip_o`  out  1  one-cycle bitslip pulse to the serdes.
- `locked_o`  out  1  block lock achieved.
- `stat_o`  out  8  status word:
  - [1:0] state code.
  - [2] locked.
  - [7:3] lock-loss count, saturating at 31.

## Operation
- A header is good when it equals 2'b01 or 2'b10. Values 2'b00 and 2'b11 are bad.
- Beats are only counted when `hdr_valid_i`=1. In `S_SLIP`, `hdr_valid_i` is ignored.
- FSM states and codes: `S_HUNT`=0, `S_SLIP`=1, `S_WAIT`=2, `S_LOCK`=3.
- `S_HUNT`: on each beat:
  - Good header: increment `good_cnt`. When the `LOCK_CNT`-th consecutive good header arrives, go to `S_LOCK`, clear `gbox_cnt` and set `locked_o`.
  - Bad header: clear `good_cnt` and go to `S_SLIP`.
- `S_SLIP`: lasts exactly one cycle.
  - If `gbox_cnt`==`GBOX_SLIPS`-1: pulse `serdes_slip_o` and clear `gbox_cnt`.
  - Otherwise: pulse `gearbox_slip_o` and increment `gbox_cnt`.
  - Then go to `S_WAIT` with `wait_cnt`=0.
- `S_WAIT`: count beats, header content ignored. After `SLIP_WAIT` beats, go to `S_HUNT` with `good_cnt`=0.
- `S_LOCK`: every beat increments `win_cnt`; a bad header also increments `err_cnt`.
  - A bad beat that makes `err_cnt` reach `ERR_LIMIT` goes to `S_SLIP`. It also clears `locked_o`, `win_cnt` and `err_cnt`, and increments the loss count (saturating).
  - Otherwise, the beat with `win_cnt`==`ERR_WINDOW`-1 clears both `win_cnt` and `err_cnt`.
  - If both happen on the same beat, the error-limit transition wins.
- Never assert `gearbox_slip_o` and `serdes_slip_o` together.
- Counter widths: `$clog2(max+1)`, no wrap. `gbox_cnt` range is 0..`GBOX_SLIPS`-1.

## Timing
- Reset: `rst_n_i` low at a clock edge → next cycle state=`S_HUNT` and all counters 0.
  - Outputs: `gearbox_slip_o`=0, `serdes_slip_o`=0, `locked_o`=0, `stat_o`=8'h00.
  - Reset mid-operation, including during `S_SLIP` or `S_WAIT`, aborts immediately. No pending slip pulse is emitted.
- All outputs are registered.
- Bad header beat sampled at edge n → slip pulse high in cycle n+1 only.
- Lock-completing beat at edge n → `locked_o`=1 from cycle n+1.
- Unlocking bad beat at edge n → `locked_o`=0 and slip pulse, both in cycle n+1.
- `stat_o` updates in the same cycle as the state register.
- Minimum spacing between two slip pulses is `SLIP_WAIT`+1 beats plus one cycle.

## Structure
- Shared package `aurora_rx_pkg` holds:
  - the state enum `sync_state_t` (with the codes above);
  - header constants `HDR_DATA`=2'b01 and `HDR_CTRL`=2'b10;
  - defaults for `LOCK_CNT`, `ERR_LIMIT`, `ERR_WINDOW`, `SLIP_WAIT`, `GBOX_SLIPS`.
- Single module with no sub-modules: one FSM plus four counters (`good_cnt`, `wait_cnt`, `gbox_cnt`, `win_cnt`/`err_cnt`).
- `aurora_rx_lane` instantiates this block and drives `gearbox_slip` and `serdes_slip` from it.

## Test plan
All scenarios use the default parameters.
- **Lock:** 64 beats of hdr 2'b01 after reset → `locked_o`=1 the cycle after the 64th beat, `stat_o`[1:0]=3, no slip pulses.
- **Slip and settle:** 10 good beats, then hdr 2'b11 → `gearbox_slip_o` high for exactly one cycle. The next 32 beats are ignored even if bad. Lock follows 64 further good beats.
- **Serdes sweep:** a continuously bad header stream → `gearbox_slip_o` pulses 65 times, then the 66th pulse is `serdes_slip_o`. `gbox_cnt` returns to 0 and the cycle repeats.
- **Error tolerance in lock:**
  - 15 bad beats in a 1024-beat window → stays locked.
  - 16th bad beat → `locked_o`=0 and a gearbox slip the next cycle, `stat_o`[7:3]=1.
- **Window wrap:** 15 bad beats in window 1, then 15 bad beats in window 2 → stays locked. A bad beat on beat 1024 that is also the 16th error → unlock, because the error limit has priority.
- **Reset during `S_WAIT`:** assert `rst_n_i`=0 for one cycle → next cycle all outputs 0, state `S_HUNT`, no stale slip pulse afterwards.

Source files
------------

// File: rtl/aurora_rx_pkg.sv
// Shared definitions for the Aurora 64b/66b receive lane: block-sync state codes,
// sync-header constants and default block-sync thresholds.
package aurora_rx_pkg;

    typedef enum logic [1:0] {
        S_HUNT = 2'd0,
        S_SLIP = 2'd1,
        S_WAIT = 2'd2,
        S_LOCK = 2'd3
    } sync_state_t;

    localparam logic [1:0] HDR_DATA = 2'b01;
    localparam logic [1:0] HDR_CTRL = 2'b10;

    localparam int LOCK_CNT_DEF   = 64;
    localparam int ERR_LIMIT_DEF  = 16;
    localparam int ERR_WINDOW_DEF = 1024;
    localparam int SLIP_WAIT_DEF  = 32;
    localparam int GBOX_SLIPS_DEF = 66;

    function automatic logic hdr_is_good(input logic [1:0] hdr);
        return (hdr == HDR_DATA) || (hdr == HDR_CTRL);
    endfunction

endpackage

// File: rtl/aurora_block_sync_ctrl.sv
// Block-sync controller: hunts for valid 66b sync headers, slips the gearbox (and the
// serdes after a full sweep) on failure, and tracks lock with a windowed error count.
module aurora_block_sync_ctrl
    import aurora_rx_pkg::*;
#(
    parameter int LOCK_CNT   = LOCK_CNT_DEF,
    parameter int ERR_LIMIT  = ERR_LIMIT_DEF,
    parameter int ERR_WINDOW = ERR_WINDOW_DEF,
    parameter int SLIP_WAIT  = SLIP_WAIT_DEF,
    parameter int GBOX_SLIPS = GBOX_SLIPS_DEF
) (
    input  logic       clk_rx_i,
    input  logic       rst_n_i,
    input  logic [1:0] hdr_i,
    input  logic       hdr_valid_i,
    output logic       gearbox_slip_o,
    output logic       serdes_slip_o,
    output logic       locked_o,
    output logic [7:0] stat_o
);

    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int WAIT_W = $clog2(SLIP_WAIT + 1);
    localparam int GBOX_W = $clog2(GBOX_SLIPS);
    localparam int WIN_W  = $clog2(ERR_WINDOW);
    localparam int ERR_W  = $clog2(ERR_LIMIT + 1);
    localparam int LOSS_W = 5;

    // hdr_i is qualified by hdr_valid_i alone; there is no backpressure, so every
    // valid beat is consumed in the cycle it is presented (and dropped in S_SLIP).
    sync_state_t       state_q, state_d;
    logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [GBOX_W-1:0] gbox_cnt_q, gbox_cnt_d;
    logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic [LOSS_W-1:0] loss_cnt_q, loss_cnt_d;
    logic              locked_q, locked_d;
    logic              gslip_q, gslip_d;
    logic              sslip_q, sslip_d;

    logic              hdr_good;
    logic              sweep_done;
    logic [ERR_W-1:0]  err_inc;

    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        wait_cnt_d = wait_cnt_q;
        gbox_cnt_d = gbox_cnt_q;
        win_cnt_d  = win_cnt_q;
        err_cnt_d  = err_cnt_q;
        loss_cnt_d = loss_cnt_q;
        locked_d   = locked_q;
        gslip_d    = 1'b0;
        sslip_d    = 1'b0;

        hdr_good   = hdr_is_good(hdr_i);
        sweep_done = (gbox_cnt_q == GBOX_W'(GBOX_SLIPS - 1));
        err_inc    = err_cnt_q + ERR_W'(1);

        // The slip pulse is registered on entry to S_SLIP so it is high exactly
        // while the FSM sits in S_SLIP; gbox_cnt itself advances during S_SLIP.
        case (state_q)
            S_HUNT: begin
                if (hdr_valid_i) begin
                    if (hdr_good) begin
                        if (good_cnt_q == GOOD_W'(LOCK_CNT - 1)) begin
                            state_d    = S_LOCK;
                            good_cnt_d = '0;
                            gbox_cnt_d = '0;
                            win_cnt_d  = '0;
                            err_cnt_d  = '0;
                            locked_d   = 1'b1;
                        end else begin
                            good_cnt_d = good_cnt_q + GOOD_W'(1);
                        end
                    end else begin
                        good_cnt_d = '0;
                        state_d    = S_SLIP;
                        gslip_d    = !sweep_done;
                        sslip_d    = sweep_done;
                    end
                end
            end
            S_SLIP: begin
                gbox_cnt_d = sweep_done ? '0 : gbox_cnt_q + GBOX_W'(1);
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (hdr_valid_i) begin
                    if (wait_cnt_q == WAIT_W'(SLIP_WAIT - 1)) begin
                        wait_cnt_d = '0;
                        good_cnt_d = '0;
                        state_d    = S_HUNT;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end
            end
            S_LOCK: begin
                if (hdr_valid_i) begin
                    // Error limit is tested first so it wins over a window rollover.
                    if (!hdr_good && (err_inc == ERR_W'(ERR_LIMIT))) begin
                        state_d   = S_SLIP;
                        locked_d  = 1'b0;
                        win_cnt_d = '0;
                        err_cnt_d = '0;
                        gslip_d   = !sweep_done;
                        sslip_d   = sweep_done;
                        if (loss_cnt_q != '1) begin
                            loss_cnt_d = loss_cnt_q + LOSS_W'(1);
                        end
                    end else if (win_cnt_q == WIN_W'(ERR_WINDOW - 1)) begin
                        win_cnt_d = '0;
                        err_cnt_d = '0;
                    end else begin
                        win_cnt_d = win_cnt_q + WIN_W'(1);
                        err_cnt_d = hdr_good ? err_cnt_q : err_inc;
                    end
                end
            end
            default: state_d = S_HUNT;
        endcase
    end

    always_ff @(posedge clk_rx_i) begin
        if (!rst_n_i) begin
            state_q    <= S_HUNT;
            good_cnt_q <= '0;
            wait_cnt_q <= '0;
            gbox_cnt_q <= '0;
            win_cnt_q  <= '0;
            err_cnt_q  <= '0;
            loss_cnt_q <= '0;
            locked_q   <= 1'b0;
            gslip_q    <= 1'b0;
            sslip_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            good_cnt_q <= good_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            gbox_cnt_q <= gbox_cnt_d;
            win_cnt_q  <= win_cnt_d;
            err_cnt_q  <= err_cnt_d;
            loss_cnt_q <= loss_cnt_d;
            locked_q   <= locked_d;
            gslip_q    <= gslip_d;
            sslip_q    <= sslip_d;
        end
    end

    assign gearbox_slip_o = gslip_q;
    assign serdes_slip_o  = sslip_q;
    assign locked_o       = locked_q;
    assign stat_o         = {loss_cnt_q, locked_q, state_q};

endmodule

// File: tb/tb_aurora_block_sync_ctrl.sv
// Directed bench for aurora_block_sync_ctrl: a table of header segments with expected
// status after each, plus hand-written reset-in-wait and serdes-sweep sequences.
module tb_aurora_block_sync_ctrl;

    logic       clk_rx_i = 1'b0;
    logic       rst_n_i;
    logic [1:0] hdr_i;
    logic       hdr_valid_i;
    logic       gearbox_slip_o;
    logic       serdes_slip_o;
    logic       locked_o;
    logic [7:0] stat_o;

    always #5 clk_rx_i = ~clk_rx_i;

    aurora_block_sync_ctrl dut (
        .clk_rx_i       (clk_rx_i),
        .rst_n_i        (rst_n_i),
        .hdr_i          (hdr_i),
        .hdr_valid_i    (hdr_valid_i),
        .gearbox_slip_o (gearbox_slip_o),
        .serdes_slip_o  (serdes_slip_o),
        .locked_o       (locked_o),
        .stat_o         (stat_o)
    );

    typedef struct {
        int         n;
        logic [1:0] hdr;
        logic       valid;
        int         exp_gs;
        int         exp_ss;
        logic [7:0] exp_stat;
    } seg_t;

    localparam int NSEG = 17;
    seg_t segs[NSEG];

    int n_cmp = 0;
    int n_fail = 0;
    int gs_total = 0;
    int ss_total = 0;
    int both_total = 0;

    task automatic observe();
        if (gearbox_slip_o) gs_total++;
        if (serdes_slip_o) ss_total++;
        if (gearbox_slip_o && serdes_slip_o) both_total++;
    endtask

    // One clock cycle: sample the outputs of the previous edge, then drive the next beat.
    task automatic tick(input logic [1:0] h, input logic v);
        @(negedge clk_rx_i);
        observe();
        hdr_i = h;
        hdr_valid_i = v;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        int gs0, ss0;
        int pulses, cyc, last_cyc, bad_spacing, bad_kind, gsb, ssb;

        //          n     hdr    vld  gs ss  stat
        segs[0]  = '{5,    2'b11, 1'b0, 0, 0, 8'h00};  // invalid beats ignored
        segs[1]  = '{63,   2'b01, 1'b1, 0, 0, 8'h00};  // one short of lock
        segs[2]  = '{1,    2'b01, 1'b1, 0, 0, 8'h07};  // 64th good -> lock
        segs[3]  = '{15,   2'b11, 1'b1, 0, 0, 8'h07};  // 15 errors tolerated
        segs[4]  = '{1,    2'b11, 1'b1, 1, 0, 8'h09};  // 16th -> unlock, slip, loss=1
        segs[5]  = '{31,   2'b11, 1'b1, 0, 0, 8'h0A};  // still waiting
        segs[6]  = '{1,    2'b11, 1'b1, 0, 0, 8'h08};  // 32nd wait beat -> hunt
        segs[7]  = '{10,   2'b01, 1'b1, 0, 0, 8'h08};
        segs[8]  = '{1,    2'b11, 1'b1, 1, 0, 8'h09};  // bad in hunt -> slip
        segs[9]  = '{32,   2'b00, 1'b1, 0, 0, 8'h08};  // bad beats ignored in wait
        segs[10] = '{64,   2'b10, 1'b1, 0, 0, 8'h0F};  // relock
        segs[11] = '{15,   2'b11, 1'b1, 0, 0, 8'h0F};  // window 1 errors
        segs[12] = '{1009, 2'b01, 1'b1, 0, 0, 8'h0F};  // closes window 1
        segs[13] = '{15,   2'b11, 1'b1, 0, 0, 8'h0F};  // window 2 errors
        segs[14] = '{1008, 2'b10, 1'b1, 0, 0, 8'h0F};  // up to beat 1023
        segs[15] = '{1,    2'b11, 1'b1, 1, 0, 8'h11};  // beat 1024 + 16th error
        segs[16] = '{10,   2'b11, 1'b1, 0, 0, 8'h12};  // inside wait

        rst_n_i = 1'b0;
        hdr_i = 2'b00;
        hdr_valid_i = 1'b0;
        repeat (3) tick(2'b00, 1'b0);
        check("reset stat", int'(stat_o), 0);
        check("reset locked", int'(locked_o), 0);
        check("reset gslip", int'(gearbox_slip_o), 0);
        check("reset sslip", int'(serdes_slip_o), 0);
        rst_n_i = 1'b1;

        for (int i = 0; i < NSEG; i++) begin
            gs0 = gs_total;
            ss0 = ss_total;
            for (int k = 0; k < segs[i].n; k++) tick(segs[i].hdr, segs[i].valid);
            tick(2'b00, 1'b0);
            check($sformatf("seg%0d stat", i), int'(stat_o), int'(segs[i].exp_stat));
            check($sformatf("seg%0d locked", i), int'(locked_o), int'(segs[i].exp_stat[2]));
            check($sformatf("seg%0d gslips", i), gs_total - gs0, segs[i].exp_gs);
            check($sformatf("seg%0d sslips", i), ss_total - ss0, segs[i].exp_ss);
        end

        // Reset while in S_WAIT, with a bad beat presented on the reset edge.
        @(negedge clk_rx_i);
        observe();
        rst_n_i = 1'b0;
        hdr_i = 2'b11;
        hdr_valid_i = 1'b1;
        @(negedge clk_rx_i);
        observe();
        rst_n_i = 1'b1;
        hdr_valid_i = 1'b0;
        check("rstwait stat", int'(stat_o), 0);
        check("rstwait locked", int'(locked_o), 0);
        check("rstwait gslip", int'(gearbox_slip_o), 0);
        check("rstwait sslip", int'(serdes_slip_o), 0);
        gs0 = gs_total;
        ss0 = ss_total;
        repeat (40) tick(2'b00, 1'b0);
        check("rstwait stale slips", (gs_total - gs0) + (ss_total - ss0), 0);
        check("rstwait idle stat", int'(stat_o), 0);

        // Continuous bad stream: 65 gearbox slips, a serdes slip, then gearbox again.
        gs0 = gs_total;
        ss0 = ss_total;
        pulses = 0;
        cyc = 0;
        last_cyc = 0;
        bad_spacing = 0;
        bad_kind = 0;
        while (pulses < 67 && cyc < 5000) begin
            gsb = gs_total;
            ssb = ss_total;
            tick(2'b11, 1'b1);
            cyc++;
            if (gs_total != gsb || ss_total != ssb) begin
                pulses++;
                if (pulses > 1 && (cyc - last_cyc) != 34) bad_spacing++;
                last_cyc = cyc;
                if ((ss_total != ssb) != (pulses == 66)) bad_kind++;
            end
        end
        check("sweep pulses seen", pulses, 67);
        check("sweep wrong pulse kind", bad_kind, 0);
        check("sweep pulse spacing", bad_spacing, 0);
        check("sweep gslip total", gs_total - gs0, 66);
        check("sweep sslip total", ss_total - ss0, 1);
        check("both slips together", both_total, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
